ghost_move_ctrl: RTL and testbench

//  Downstream consumer of a ghost direction controller. Turns the registered 2-bit

---
 rtl/ghost_move_ctrl_pkg.sv | 30 +++
 rtl/ghost_move_ctrl_if.sv | 38 +++
 rtl/ghost_move_ctrl_tile_step.sv | 73 +++++++
 rtl/ghost_move_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ghost_move_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/ghost_move_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ghost_move_ctrl_pkg
//  Purpose  : Shared direction/mode codes and maze geometry defaults for the
//             ghost mover and its tile stepper.
//  Revision : 1.0  initial release
// ============================================================================
package ghost_move_ctrl_pkg;

    // Maze geometry and home tile defaults
    localparam int c_map_w  = 10;
    localparam int c_map_h  = 9;
    localparam int c_home_x = 8;
    localparam int c_home_y = 1;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_FRIGHT = 2'b01,
        MODE_EATEN  = 2'b10
    } mode_t;

endpackage
`default_nettype wire

// File: rtl/ghost_move_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : ghost_move_ctrl_if
//  Purpose  : Bundles the ghost mover's game-side signals.
//  Ports    : tick_bit, power, map, dir, pac_x, pac_y  (into the mover)
//             ghost_x, ghost_y, ghost_mode, caught_pac, ghost_eaten (out)
//             master = game side, slave = ghost mover.
//  Revision : 1.0  initial release
// ============================================================================
interface ghost_move_ctrl_if
    import ghost_move_ctrl_pkg::*;
#(
    parameter int MAP_W = c_map_w,
    parameter int MAP_H = c_map_h
);
    logic                     tick_bit;
    logic                     power;
    logic [0:MAP_W*MAP_H-1]   map;
    logic [1:0]               dir;
    logic [4:0]               pac_x;
    logic [4:0]               pac_y;
    logic [4:0]               ghost_x;
    logic [4:0]               ghost_y;
    logic [1:0]               ghost_mode;
    logic                     caught_pac;
    logic                     ghost_eaten;

    modport master (
        output tick_bit, power, map, dir, pac_x, pac_y,
        input  ghost_x, ghost_y, ghost_mode, caught_pac, ghost_eaten
    );

    modport slave (
        input  tick_bit, power, map, dir, pac_x, pac_y,
        output ghost_x, ghost_y, ghost_mode, caught_pac, ghost_eaten
    );
endinterface
`default_nettype wire

// File: rtl/ghost_move_ctrl_tile_step.sv
`default_nettype none
// ============================================================================
//  Module   : tile_step
//  Purpose  : Combinational one-tile move on the maze map. Returns the tile
//             reached from (x,y) in direction dir, or (x,y) itself when the
//             move is blocked by a vertical edge, a non-wrapping horizontal
//             edge, or a wall.
//  Ports    : x, y, dir, map -> nx, ny, blocked
//  Revision : 1.0  initial release
// ============================================================================
module tile_step
    import ghost_move_ctrl_pkg::*;
#(
    parameter int MAP_W = c_map_w,
    parameter int MAP_H = c_map_h,
    parameter bit WRAP  = 1'b1
) (
    input  wire logic [4:0]             x,
    input  wire logic [4:0]             y,
    input  wire logic [1:0]             dir,
    input  wire logic [0:MAP_W*MAP_H-1] map,
    output logic      [4:0]             nx,
    output logic      [4:0]             ny,
    output logic                        blocked
);
    localparam logic [6:0] c_cells = 7'(MAP_W * MAP_H);

    logic [4:0] w_cx;
    logic [4:0] w_cy;
    logic       w_edge;
    logic [6:0] w_idx;
    logic       w_wall;

    always_comb begin
        w_cx   = x;
        w_cy   = y;
        w_edge = 1'b0;
        case (dir)
            DIR_UP: begin
                if (y == 5'd0) w_edge = 1'b1;
                else           w_cy   = y - 5'd1;
            end
            DIR_DOWN: begin
                if (y == 5'(MAP_H - 1)) w_edge = 1'b1;
                else                    w_cy   = y + 5'd1;
            end
            DIR_LEFT: begin
                if (x == 5'd0) begin
                    if (WRAP) w_cx   = 5'(MAP_W - 1);
                    else      w_edge = 1'b1;
                end else begin
                    w_cx = x - 5'd1;
                end
            end
            default: begin
                if (x == 5'(MAP_W - 1)) begin
                    if (WRAP) w_cx   = 5'd0;
                    else      w_edge = 1'b1;
                end else begin
                    w_cx = x + 5'd1;
                end
            end
        endcase
    end

    // 7-bit index so y*MAP_W+x never truncates; off-map tiles count as walls
    assign w_idx   = {2'b00, w_cy} * 7'(MAP_W) + {2'b00, w_cx};
    assign w_wall  = (w_idx < c_cells) ? map[w_idx] : 1'b1;
    assign blocked = w_edge | w_wall;
    assign nx      = blocked ? x : w_cx;
    assign ny      = blocked ? y : w_cy;
endmodule
`default_nettype wire

// File: rtl/ghost_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ghost_move_ctrl
//  Purpose  : Moves the ghost one tile per move tick in the direction given
//             by the direction controller; owns ghost position, the
//             NORMAL/FRIGHT/EATEN mode machine and pac collision pulses.
//  Ports    : clk, rst_n (async active-low), bus (slave modport: tick_bit,
//             power, map, dir, pac_x/y in; ghost_x/y, ghost_mode,
//             caught_pac, ghost_eaten out)
//  Revision : 1.0  initial release
// ============================================================================
module ghost_move_ctrl
    import ghost_move_ctrl_pkg::*;
#(
    parameter int MAP_W         = c_map_w,
    parameter int MAP_H         = c_map_h,
    parameter int HOME_X        = c_home_x,
    parameter int HOME_Y        = c_home_y,
    parameter int FRIGHT_STEPS  = 16,
    parameter int RESPAWN_STEPS = 8,
    parameter bit WRAP          = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    ghost_move_ctrl_if.slave  bus
);
    mode_t      r_state,    w_state_nxt;
    logic [4:0] r_x,        w_x_nxt;
    logic [4:0] r_y,        w_y_nxt;
    logic [7:0] r_fr_cnt,   w_fr_cnt_nxt;
    logic [7:0] r_rs_cnt,   w_rs_cnt_nxt;
    logic       r_half,     w_half_nxt;
    logic       r_caught,   w_caught_nxt;
    logic       r_eaten,    w_eaten_nxt;
    logic       r_tick_q;
    logic       r_power_q;
    logic       r_overlap_q;

    logic       w_step;
    logic       w_pwr_ev;
    logic       w_overlap;
    logic [4:0] w_nx;
    logic [4:0] w_ny;
    logic       w_blocked;
    logic       w_move_ok;

    assign w_step    = bus.tick_bit & ~r_tick_q;
    assign w_pwr_ev  = bus.power & ~r_power_q;
    assign w_overlap = (r_x == bus.pac_x) && (r_y == bus.pac_y);
    assign w_move_ok = w_step & ~w_blocked;

    tile_step #(
        .MAP_W (MAP_W),
        .MAP_H (MAP_H),
        .WRAP  (WRAP)
    ) u_tile_step (
        .x       (r_x),
        .y       (r_y),
        .dir     (bus.dir),
        .map     (bus.map),
        .nx      (w_nx),
        .ny      (w_ny),
        .blocked (w_blocked)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= MODE_NORMAL;
            r_x         <= 5'(HOME_X);
            r_y         <= 5'(HOME_Y);
            r_fr_cnt    <= '0;
            r_rs_cnt    <= '0;
            r_half      <= 1'b0;
            r_caught    <= 1'b0;
            r_eaten     <= 1'b0;
            r_tick_q    <= 1'b0;
            r_power_q   <= 1'b0;
            r_overlap_q <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_fr_cnt    <= w_fr_cnt_nxt;
            r_rs_cnt    <= w_rs_cnt_nxt;
            r_half      <= w_half_nxt;
            r_caught    <= w_caught_nxt;
            r_eaten     <= w_eaten_nxt;
            r_tick_q    <= bus.tick_bit;
            r_power_q   <= bus.power;
            r_overlap_q <= w_overlap;
        end
    end

    // Priority inside each state: collision transition, then power event,
    // then the step (a cycle that changes mode never also moves).
    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_fr_cnt_nxt = r_fr_cnt;
        w_rs_cnt_nxt = r_rs_cnt;
        w_half_nxt   = r_half;
        w_caught_nxt = 1'b0;
        w_eaten_nxt  = 1'b0;
        case (r_state)
            MODE_NORMAL: begin
                if (w_pwr_ev) begin
                    w_state_nxt  = MODE_FRIGHT;
                    w_fr_cnt_nxt = '0;
                    w_half_nxt   = 1'b0;
                end else begin
                    // Only the first cycle of a contact raises the pulse
                    w_caught_nxt = w_overlap & ~r_overlap_q;
                    if (w_move_ok) begin
                        w_x_nxt = w_nx;
                        w_y_nxt = w_ny;
                    end
                end
            end
            MODE_FRIGHT: begin
                if (w_overlap) begin
                    w_state_nxt  = MODE_EATEN;
                    w_eaten_nxt  = 1'b1;
                    w_x_nxt      = 5'(HOME_X);
                    w_y_nxt      = 5'(HOME_Y);
                    w_rs_cnt_nxt = '0;
                end else if (w_pwr_ev) begin
                    w_fr_cnt_nxt = '0;
                    w_half_nxt   = 1'b0;
                end else if (w_step) begin
                    // Half speed: move on every second step
                    w_half_nxt = ~r_half;
                    if (r_half && !w_blocked) begin
                        w_x_nxt = w_nx;
                        w_y_nxt = w_ny;
                    end
                    if (r_fr_cnt == 8'(FRIGHT_STEPS - 1)) begin
                        w_state_nxt  = MODE_NORMAL;
                        w_fr_cnt_nxt = '0;
                    end else begin
                        w_fr_cnt_nxt = r_fr_cnt + 8'd1;
                    end
                end
            end
            MODE_EATEN: begin
                w_x_nxt = 5'(HOME_X);
                w_y_nxt = 5'(HOME_Y);
                if (w_step) begin
                    if (r_rs_cnt == 8'(RESPAWN_STEPS - 1)) begin
                        w_state_nxt  = MODE_NORMAL;
                        w_rs_cnt_nxt = '0;
                    end else begin
                        w_rs_cnt_nxt = r_rs_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = MODE_NORMAL;
            end
        endcase
    end

    assign bus.ghost_x     = r_x;
    assign bus.ghost_y     = r_y;
    assign bus.ghost_mode  = r_state;
    assign bus.caught_pac  = r_caught;
    assign bus.ghost_eaten = r_eaten;
endmodule
`default_nettype wire

// File: tb/tb_ghost_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ghost_move_ctrl
//  Purpose  : Directed self-checking bench for ghost_move_ctrl; a second
//             instance with WRAP=0 covers the blocked horizontal edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ghost_move_ctrl;
    import ghost_move_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        tick_bit;
    logic        power;
    logic [0:89] map_v;
    logic [1:0]  dir;
    logic [4:0]  pac_x;
    logic [4:0]  pac_y;

    int n_pass  = 0;
    int n_total = 0;

    ghost_move_ctrl_if bus1 ();
    ghost_move_ctrl_if bus2 ();

    assign bus1.tick_bit = tick_bit;
    assign bus1.power    = power;
    assign bus1.map      = map_v;
    assign bus1.dir      = dir;
    assign bus1.pac_x    = pac_x;
    assign bus1.pac_y    = pac_y;
    assign bus2.tick_bit = tick_bit;
    assign bus2.power    = power;
    assign bus2.map      = map_v;
    assign bus2.dir      = dir;
    assign bus2.pac_x    = pac_x;
    assign bus2.pac_y    = pac_y;

    ghost_move_ctrl #(.WRAP(1'b1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    ghost_move_ctrl #(.WRAP(1'b0)) u_dut_nowrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One rising edge of tick_bit, then let the pulse registers settle
    task automatic do_step();
        tick_bit = 1'b1;
        cyc();
        tick_bit = 1'b0;
        cyc();
    endtask

    task automatic steps(input logic [1:0] d, input int n);
        dir = d;
        for (int i = 0; i < n; i++) do_step();
    endtask

    initial begin
        rst_n    = 1'b0;
        tick_bit = 1'b0;
        power    = 1'b0;
        map_v    = '0;
        dir      = DIR_UP;
        pac_x    = 5'd31;
        pac_y    = 5'd31;
        cyc();
        cyc();

        // Reset state
        chk("rst_x",      bus1.ghost_x, 8);
        chk("rst_y",      bus1.ghost_y, 1);
        chk("rst_mode",   bus1.ghost_mode, 0);
        chk("rst_caught", bus1.caught_pac, 0);
        chk("rst_eaten",  bus1.ghost_eaten, 0);

        rst_n = 1'b1;
        cyc();

        // Walk to (3,4) in an open maze
        steps(DIR_LEFT, 5);
        steps(DIR_DOWN, 3);
        chk("walk_x", bus1.ghost_x, 3);
        chk("walk_y", bus1.ghost_y, 4);

        // Corridor: one tile per tick edge, one cycle after the step edge
        dir = DIR_RIGHT;
        tick_bit = 1'b1;
        cyc();
        chk("corr_x1", bus1.ghost_x, 4);
        tick_bit = 1'b0;
        cyc();
        tick_bit = 1'b1;
        cyc();
        chk("corr_x2", bus1.ghost_x, 5);
        tick_bit = 1'b0;
        cyc();
        tick_bit = 1'b1;
        cyc();
        chk("corr_x3", bus1.ghost_x, 6);
        cyc();
        chk("corr_hold_high", bus1.ghost_x, 6);
        tick_bit = 1'b0;
        cyc();

        // Wall at (4,4) blocks a ghost at (3,4) moving right
        steps(DIR_LEFT, 3);
        map_v[44] = 1'b1;
        steps(DIR_RIGHT, 2);
        chk("wall_x",    bus1.ghost_x, 3);
        chk("wall_y",    bus1.ghost_y, 4);
        chk("wall_mode", bus1.ghost_mode, 0);
        map_v[44] = 1'b0;

        // Horizontal edge from (0,2): wrap vs blocked
        steps(DIR_LEFT, 3);
        steps(DIR_UP, 2);
        chk("edge_pre_x", bus1.ghost_x, 0);
        chk("edge_pre_y", bus1.ghost_y, 2);
        steps(DIR_LEFT, 1);
        chk("wrap_x",    bus1.ghost_x, 9);
        chk("wrap_y",    bus1.ghost_y, 2);
        chk("nowrap_x",  bus2.ghost_x, 0);
        chk("nowrap_y",  bus2.ghost_y, 2);

        // Top edge never wraps
        steps(DIR_UP, 3);
        chk("top_edge_y", bus1.ghost_y, 0);
        chk("top_edge_x", bus1.ghost_x, 9);

        // Catch pac at (5,5) in NORMAL: single pulse
        pac_x = 5'd5;
        pac_y = 5'd5;
        steps(DIR_DOWN, 5);
        steps(DIR_LEFT, 4);
        chk("catch_x",     bus1.ghost_x, 5);
        chk("catch_pulse", bus1.caught_pac, 1);
        cyc();
        chk("catch_once",  bus1.caught_pac, 0);
        map_v[54] = 1'b1;
        steps(DIR_LEFT, 1);
        chk("catch_hold_x",   bus1.ghost_x, 5);
        chk("catch_no_again", bus1.caught_pac, 0);
        map_v[54] = 1'b0;

        // FRIGHT: half speed, lasts 16 steps
        pac_x = 5'd31;
        pac_y = 5'd31;
        power = 1'b1;
        cyc();
        chk("fr_enter", bus1.ghost_mode, 1);
        steps(DIR_RIGHT, 4);
        chk("fr_half_x", bus1.ghost_x, 7);
        map_v[56] = 1'b1;
        steps(DIR_LEFT, 11);
        chk("fr_step15_mode", bus1.ghost_mode, 1);
        chk("fr_step15_x",    bus1.ghost_x, 7);
        steps(DIR_LEFT, 1);
        chk("fr_exit_mode", bus1.ghost_mode, 0);
        map_v[56] = 1'b0;
        power = 1'b0;
        cyc();

        // FRIGHT ghost reaches pac -> eaten, home, respawn after 8 steps
        pac_x = 5'd8;
        pac_y = 5'd5;
        power = 1'b1;
        cyc();
        steps(DIR_RIGHT, 2);
        chk("eat_pulse", bus1.ghost_eaten, 1);
        chk("eat_mode",  bus1.ghost_mode, 2);
        chk("eat_home_x", bus1.ghost_x, 8);
        chk("eat_home_y", bus1.ghost_y, 1);
        cyc();
        chk("eat_once", bus1.ghost_eaten, 0);
        steps(DIR_DOWN, 7);
        chk("eat_step7_mode", bus1.ghost_mode, 2);
        chk("eat_ignores_dir", bus1.ghost_y, 1);
        steps(DIR_DOWN, 1);
        chk("respawn_mode", bus1.ghost_mode, 0);
        power = 1'b0;
        cyc();

        // Enter EATEN again at home, then reset asynchronously mid-EATEN
        pac_x = 5'd8;
        pac_y = 5'd1;
        cyc();
        cyc();
        power = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("eat2_mode", bus1.ghost_mode, 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_mode",   bus1.ghost_mode, 0);
        chk("arst_x",      bus1.ghost_x, 8);
        chk("arst_y",      bus1.ghost_y, 1);
        chk("arst_caught", bus1.caught_pac, 0);
        chk("arst_eaten",  bus1.ghost_eaten, 0);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
